// File: rtl/scan_disp_pkg.sv
// Shared definitions for multiplexed 7-segment display blocks:
// digit nibble type, segment glyphs and the radix legality check.
package scan_disp_pkg;

    typedef logic [3:0] nibble_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic bit radix_ok(input int radix);
        return (radix == 10) || (radix == 16);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment glyph decoder (A, b, C, d, E, F).
module seg7_hex_decode
    import scan_disp_pkg::*;
(
    input  nibble_t    digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scan_bcd_counter_display.sv
// Multi-digit up/down counter (radix 10/16) with prescaler and load, driving
// a time-multiplexed 7-segment bus with leading-zero blanking and a heartbeat dp.
module scan_bcd_counter_display
    import scan_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int RADIX    = 10,
    parameter int PRESCALE = 1,
    parameter int SCAN_DIV = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  input_clock1_1,
    input  logic                  input_reset_n1_2,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   load_val,
    output logic [DIGITS*4-1:0]   count_q,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam nibble_t TOP = nibble_t'(RADIX - 1);

    if (!radix_ok(RADIX)) begin : g_bad_radix
        $error("scan_bcd_counter_display: RADIX must be 10 or 16");
    end

    logic [PW-1:0]       presc;
    logic                tick;
    logic                hb;
    logic [DIGITS*4-1:0] cnt_next;
    logic [DIGITS*4-1:0] load_sat;
    logic                wrap;
    logic [SW-1:0]       scan_div;
    logic [IW-1:0]       idx;
    logic [DIGITS-1:0]   blank;
    nibble_t             digs [DIGITS];
    logic [6:0]          dec_seg;

    assign tick = en && (presc == PW'(PRESCALE - 1));

    // Ripple carry/borrow across digits; wrap means every digit was terminal.
    always_comb begin
        logic    carry;
        logic    hi_zero;
        nibble_t d;
        nibble_t nd;
        cnt_next = count_q;
        load_sat = '0;
        blank    = '0;
        wrap     = 1'b1;
        carry    = 1'b1;
        hi_zero  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d       = count_q[i*4 +: 4];
            digs[i] = d;
            if (up) begin
                nd = (d == TOP) ? 4'd0 : d + 4'd1;
                if (d != TOP) wrap = 1'b0;
            end else begin
                nd = (d == 4'd0) ? TOP : d - 4'd1;
                if (d != 4'd0) wrap = 1'b0;
            end
            if (carry) cnt_next[i*4 +: 4] = nd;
            carry = carry && (up ? (d == TOP) : (d == 4'd0));
            d = load_val[i*4 +: 4];
            load_sat[i*4 +: 4] = (d > TOP) ? TOP : d;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero  = hi_zero && (count_q[i*4 +: 4] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i > 0) && hi_zero;
        end
    end

    always_ff @(posedge input_clock1_1 or negedge input_reset_n1_2) begin
        if (!input_reset_n1_2) begin
            count_q <= '0;
            presc   <= '0;
            hb      <= 1'b0;
            tc      <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            presc   <= '0;
            hb      <= 1'b0;
            tc      <= 1'b0;
        end else if (load) begin
            count_q <= load_sat;
            presc   <= '0;
            tc      <= 1'b0;
        end else begin
            tc <= tick && wrap;
            if (en) presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                count_q <= cnt_next;
                hb      <= ~hb;
            end
        end
    end

    seg7_hex_decode u_dec (
        .digit (digs[idx]),
        .seg   (dec_seg)
    );

    // Display registers sample the pre-edge index and count.
    always_ff @(posedge input_clock1_1 or negedge input_reset_n1_2) begin
        if (!input_reset_n1_2) begin
            scan_div  <= '0;
            idx       <= '0;
            digit_sel <= '0;
            seg       <= SEG_BLANK;
            dp        <= 1'b0;
        end else begin
            if (scan_div == SW'(SCAN_DIV - 1)) begin
                scan_div <= '0;
                idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                scan_div <= scan_div + SW'(1);
            end
            digit_sel <= DIGITS'(1) << idx;
            seg       <= blank[idx] ? SEG_BLANK : dec_seg;
            dp        <= (idx == '0) && hb;
        end
    end

endmodule

// File: tb/tb_scan_bcd_counter_display.sv
// Scoreboard bench: four configurations share one stimulus stream; each step
// queues hand-computed expectations that a negedge monitor pops and compares.
module tb_scan_bcd_counter_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;

    always #5 clk = ~clk;

    logic [15:0] a_q;  logic a_tc; logic [6:0] a_seg; logic a_dp; logic [3:0] a_sel;
    logic [7:0]  b_q;  logic b_tc; logic [6:0] b_seg; logic b_dp; logic [1:0] b_sel;
    logic [3:0]  c_q;  logic c_tc; logic [6:0] c_seg; logic c_dp; logic [0:0] c_sel;
    logic [15:0] d_q;  logic d_tc; logic [6:0] d_seg; logic d_dp; logic [3:0] d_sel;

    scan_bcd_counter_display #(.DIGITS(4), .RADIX(10), .PRESCALE(1), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
        .input_clock1_1(clk), .input_reset_n1_2(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count_q(a_q), .tc(a_tc), .seg(a_seg), .dp(a_dp), .digit_sel(a_sel));
    scan_bcd_counter_display #(.DIGITS(2), .RADIX(16), .PRESCALE(1), .SCAN_DIV(4), .BLANK_LZ(1)) u_b (
        .input_clock1_1(clk), .input_reset_n1_2(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[7:0]), .count_q(b_q), .tc(b_tc), .seg(b_seg), .dp(b_dp), .digit_sel(b_sel));
    scan_bcd_counter_display #(.DIGITS(1), .RADIX(10), .PRESCALE(5), .SCAN_DIV(1), .BLANK_LZ(1)) u_c (
        .input_clock1_1(clk), .input_reset_n1_2(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .count_q(c_q), .tc(c_tc), .seg(c_seg), .dp(c_dp), .digit_sel(c_sel));
    scan_bcd_counter_display #(.DIGITS(4), .RADIX(10), .PRESCALE(1), .SCAN_DIV(2), .BLANK_LZ(1)) u_d (
        .input_clock1_1(clk), .input_reset_n1_2(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count_q(d_q), .tc(d_tc), .seg(d_seg), .dp(d_dp), .digit_sel(d_sel));

    localparam int DA = 0, DB = 1, DC = 2, DD = 3;
    localparam int FQ = 0, FTC = 1, FSEG = 2, FDP = 3, FSEL = 4;

    typedef struct {
        int          cyc;
        int          dut;
        int          fld;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   c0 = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int d, input int f);
        logic [15:0] q; logic t; logic [6:0] s; logic p; logic [3:0] ds;
        case (d)
            DA:      begin q = a_q;           t = a_tc; s = a_seg; p = a_dp; ds = a_sel;          end
            DB:      begin q = {8'h0, b_q};   t = b_tc; s = b_seg; p = b_dp; ds = {2'b0, b_sel};  end
            DC:      begin q = {12'h0, c_q};  t = c_tc; s = c_seg; p = c_dp; ds = {3'b0, c_sel};  end
            default: begin q = d_q;           t = d_tc; s = d_seg; p = d_dp; ds = d_sel;          end
        endcase
        case (f)
            FQ:      return 32'(q);
            FTC:     return 32'(t);
            FSEG:    return 32'(s);
            FDP:     return 32'(p);
            default: return 32'(ds);
        endcase
    endfunction

    task automatic exp_at(input int d, input int f, input int v, input string n);
        exp_t e;
        e.cyc = cyc; e.dut = d; e.fld = f; e.exp = 32'(v); e.name = n;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_reset(input int d, input string n);
        exp_at(d, FQ, 0, n); exp_at(d, FTC, 0, n); exp_at(d, FSEG, 0, n);
        exp_at(d, FDP, 0, n); exp_at(d, FSEL, 0, n);
    endtask

    // Monitor: compare every expectation due in the current cycle.
    initial begin
        logic [31:0] act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    act = actual(sb[i].dut, sb[i].fld);
                    checks++;
                    if (act !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s (dut %0d fld %0d cyc %0d): got %0h, want %0h",
                                 sb[i].name, sb[i].dut, sb[i].fld, cyc, act, sb[i].exp);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        logic [6:0] d_glyph [4];
        int r, ix;
        d_glyph = '{7'h3F, 7'h07, 7'h00, 7'h00};

        step(1);
        exp_reset(DA, "reset_a");
        exp_reset(DB, "reset_b");
        rst_n = 1'b1;
        c0 = cyc;
        step(1);
        exp_at(DA, FSEL, 4'b0001, "sel_after_release_a");
        exp_at(DD, FSEL, 4'b0001, "sel_after_release_d");

        // scan walk with leading-zero blanking on 0x0070
        load = 1'b1; load_val = 16'h0070;
        step(1);
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            r  = cyc - c0;
            ix = ((r - 1) / 2) % 4;
            exp_at(DD, FSEL, 1 << ix, "scan_sel");
            exp_at(DD, FSEG, int'(d_glyph[ix]), "scan_seg");
        end

        // decimal up wrap
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h9998;
        step(1); exp_at(DA, FQ, 16'h9998, "upwrap_load"); exp_at(DA, FTC, 0, "upwrap_tc0");
        load = 1'b0;
        step(1); exp_at(DA, FQ, 16'h9999, "upwrap_9999"); exp_at(DA, FTC, 0, "upwrap_tc1");
        step(1); exp_at(DA, FQ, 16'h0000, "upwrap_0000"); exp_at(DA, FTC, 1, "upwrap_tc_pulse");
        step(1); exp_at(DA, FQ, 16'h0001, "upwrap_0001"); exp_at(DA, FTC, 0, "upwrap_tc_end");

        // priority: clr over load, load over tick
        en = 1'b0; clr = 1'b1; load = 1'b1; load_val = 16'h1234;
        step(1); exp_at(DA, FQ, 0, "prio_clr"); exp_at(DA, FTC, 0, "prio_clr_tc");
        clr = 1'b0;
        step(1); exp_at(DA, FQ, 16'h1234, "prio_load"); exp_at(DA, FTC, 0, "prio_load_tc");
        en = 1'b1; load_val = 16'h0005;
        step(1); exp_at(DA, FQ, 16'h0005, "load_beats_tick");
        load = 1'b0;
        step(1); exp_at(DA, FQ, 16'h0006, "tick_after_load"); exp_at(DA, FTC, 0, "tick_after_load_tc");

        // load saturation (decimal) vs pass-through (hex)
        en = 1'b0; load = 1'b1; load_val = 16'hFA0C;
        step(1); exp_at(DA, FQ, 16'h9909, "sat_dec"); exp_at(DB, FQ, 8'h0C, "nosat_hex");

        // hex down wrap
        load_val = 16'h0001;
        step(1); exp_at(DB, FQ, 8'h01, "down_load");
        load = 1'b0; en = 1'b1; up = 1'b0;
        step(1); exp_at(DB, FQ, 8'h00, "down_00"); exp_at(DB, FTC, 0, "down_tc0");
        step(1); exp_at(DB, FQ, 8'hFF, "down_FF"); exp_at(DB, FTC, 1, "down_tc_pulse");
        step(1); exp_at(DB, FQ, 8'hFE, "down_FE"); exp_at(DB, FTC, 0, "down_tc_end");

        // prescaler 5 with heartbeat on dp
        en = 1'b0; up = 1'b1; clr = 1'b1;
        step(1);
        clr = 1'b0; en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp_at(DC, FQ, k / 5, "presc_count");
            exp_at(DC, FDP, ((k - 1) / 5) % 2, "presc_dp");
        end
        step(1); exp_at(DC, FQ, 4, "gap_21");
        step(1); exp_at(DC, FQ, 4, "gap_22");
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1); exp_at(DC, FQ, 4, "gap_hold");
        end
        en = 1'b1;
        step(1); exp_at(DC, FQ, 4, "gap_26");
        step(1); exp_at(DC, FQ, 4, "gap_27");
        step(1); exp_at(DC, FQ, 5, "gap_tick_delayed");

        // asynchronous reset mid-count
        en = 1'b0; load = 1'b1; load_val = 16'h0042;
        step(1); exp_at(DA, FQ, 16'h0042, "pre_reset_count");
        load = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        exp_reset(DA, "async_reset");
        step(1);
        rst_n = 1'b1;
        c0 = cyc;
        step(1);
        exp_at(DA, FSEL, 4'b0001, "sel_after_rerelease");
        exp_at(DA, FQ, 0, "count_after_rerelease");

        step(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_bcd_counter_display.md
Name: scan_bcd_counter_display

Overview:
- Parametrised successor to the single-digit 4-bit counter/7-segment block.
- Multi-digit synchronous up/down counter, radix 10 or 16 per digit, with prescaler, parallel load and terminal-count pulse.
- Drives a time-multiplexed common bus of 7-segment displays (one digit lit at a time) plus a heartbeat decimal point.
- Sits between board inputs (clock, push buttons, switches) and the 7-segment display elements.

Parameters:
- DIGITS, 4, number of digits (1..8)
- RADIX, 10, per-digit radix; only 10 or 16 legal
- PRESCALE, 1, clock cycles per count tick (>=1)
- SCAN_DIV, 4, clock cycles each digit stays selected (>=1)
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 never blanked)

Ports:
- input_clock1_1  in  1  system clock, all logic on rising edge
- input_reset_n1_2  in  1  asynchronous active-low reset
- en  in  1  count enable
- up  in  1  1 = count up, 0 = count down
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load
- load_val  in  DIGITS*4  load data, digit 0 in bits [3:0]
- count_q  out  DIGITS*4  current count, one nibble per digit
- tc  out  1  one-cycle pulse on wrap
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp  out  1  decimal point, active-high
- digit_sel  out  DIGITS  one-hot digit enable, active-high

Behaviour:
- Reset (async, input_reset_n1_2=0):
  - count_q=0, tc=0, seg=0, dp=0, digit_sel=0.
  - Prescaler=0, scan index=0, scan divider=0, heartbeat=0.
- Priority each cycle: clr > load > count tick.
- clr=1:
  - count_q=0, prescaler=0, heartbeat=0, tc=0.
  - Scan logic keeps running.
- load=1:
  - count_q=load_val, with any nibble >= RADIX saturated to RADIX-1.
  - Prescaler=0, tc=0.
- Prescaler:
  - When en=1, counts 0..PRESCALE-1; tick asserted in the cycle it equals PRESCALE-1, then it wraps to 0.
  - en=0 holds the prescaler.
  - PRESCALE=1 gives a tick every enabled cycle.
- Tick, up=1:
  - Digit 0 increments; a digit at RADIX-1 rolls to 0 and carries to the next digit (ripple within one cycle).
  - All digits at RADIX-1 -> all 0, tc=1 for exactly the next cycle.
- Tick, up=0:
  - Borrow chain; digit at 0 rolls to RADIX-1.
  - All digits 0 -> all RADIX-1, tc=1.
- count_q updates on the clock edge that samples the tick (1-cycle latency from tick).
- Heartbeat toggles on every tick.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1; at SCAN_DIV-1 the scan index advances (DIGITS-1 wraps to 0).
  - First scan step begins the first cycle after reset release.
- Outputs are registered (1 cycle after index change):
  - digit_sel = one-hot of index.
  - seg = decode(count_q nibble[index]).
  - dp = heartbeat when index==0, else 0.
- Decode:
  - Hex 0-F standard glyphs (A, b, C, d, E, F).
  - When RADIX=10, nibble values >= 10 cannot occur.
- Blanking: with BLANK_LZ=1, digit i>0 drives seg=0 when it and all higher digits are 0; digit_sel still asserted.
- Simultaneous events:
  - clr with load -> clear.
  - load with tick -> load, tick discarded.
  - Counter wrap and scan step in the same cycle -> both take effect; the displayed value uses the pre-edge count_q.

Decomposition:
- Shared package scan_disp_pkg holds:
  - SEG_* glyph constants for 0-F, and SEG_BLANK.
  - Function for legal RADIX check.
  - Digit nibble typedef (4-bit).
- One natural sub-module: seg7_hex_decode (combinational, 4-bit in -> 7-bit segments), reused by other display blocks.
- Top contains prescaler, counter chain, scan FSM (index + divider) and output registers.

Test Plan:
- Reset/default (DIGITS=4, RADIX=10, PRESCALE=1):
  - Reset asserted mid-count at count_q=0x0042 -> all outputs 0 immediately, without waiting for a clock edge.
  - After release, digit_sel=4'b0001 within 2 cycles.
- Up wrap (RADIX=10):
  - load_val=0x9998, en=1, up=1 -> 0x9999 next tick, then 0x0000.
  - tc high exactly one cycle, coincident with the 0x0000 cycle.
- Down wrap (RADIX=16, DIGITS=2):
  - load 0x01, up=0 -> 0x00, then 0xFF with tc pulse.
  - load_val=0xAC with RADIX=10 -> count_q=0x99.
- Prescaler (PRESCALE=5):
  - en high 20 cycles from count 0 -> count_q=4, dp heartbeat toggled 4 times.
  - Dropping en for 3 cycles mid-period delays the next tick by exactly 3.
- Scan/blank (SCAN_DIV=2, BLANK_LZ=1):
  - count_q=0x0070 -> digit_sel walks 0001,0010,0100,1000, changing every 2 cycles.
  - seg: 0x3F (0), 0x07 (7), 0x00 (blank), 0x00 (blank).
- Priority: clr and load asserted in the same cycle with load_val=0x1234 -> count_q=0; next cycle load alone -> 0x1234, tc=0 throughout.
